uart_tx_result: RTL and testbench

UART transmitter that returns LeNet-5 inference results from the FPGA to the host PC over the same serial link used to load images. On a one-cycle `start` pulse it latches a packed vector of `NUM_BYTES` bytes and serialises it as back-to-back 8N1 frames at the project baud rate (434 clocks per bit: 50 MHz, 115200 baud). It sits after the classifier/argmax stage and drives the board TX pin.

---
 rtl/uart_tx_result_if.sv | 28 ++
 rtl/uart_tx_result.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_result.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_result_if.sv
// rtl/uart_tx_result_if.sv - request/status/serial bundle between result source and UART transmitter
interface uart_tx_result_if #(
  parameter int NUM_BYTES = 10
) ();
  logic                   start;
  logic [8*NUM_BYTES-1:0] d_in;
  logic                   busy;
  logic                   done;
  logic                   bit_out;

  // Result source: issues transfer requests and watches status and the line
  modport master (
    output start,
    output d_in,
    input  busy,
    input  done,
    input  bit_out
  );

  // Transmitter: consumes requests, drives status and the TX pin
  modport slave (
    input  start,
    input  d_in,
    output busy,
    output done,
    output bit_out
  );
endinterface

// File: rtl/uart_tx_result.sv
// rtl/uart_tx_result.sv - multi-byte 8N1 UART transmitter for inference result vectors
module uart_tx_result #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 10,
  parameter int MSB_FIRST    = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_result_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 state_q,    state_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [2:0]             bit_idx_q,  bit_idx_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [8*NUM_BYTES-1:0] payload_q,  payload_d;
  logic [7:0]             shift_q,    shift_d;
  logic                   bit_out_q,  bit_out_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;
  logic                   bit_end;

  // Byte k of the payload lives at the top end: byte 0 is the most significant byte.
  // A constant-index loop keeps every part-select in range for any NUM_BYTES.
  function automatic logic [7:0] pick_byte(
    input logic [8*NUM_BYTES-1:0] p,
    input logic [IDX_W-1:0]       idx
  );
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (idx == IDX_W'(b)) begin
        r = p[8*(NUM_BYTES-b)-1 -: 8];
      end
    end
    return r;
  endfunction

  assign bit_end = (cnt_q == LAST_CNT);

  // Next-state logic: frame sequencing, counters, shifter and registered line/status values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    payload_d  = payload_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (bus.start) begin
          // Snapshot the whole vector so later d_in changes cannot corrupt this transfer
          payload_d  = bus.d_in;
          shift_d    = bus.d_in[8*NUM_BYTES-1 -: 8];
          byte_idx_d = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (MSB_FIRST != 0) begin
            shift_d = {shift_q[6:0], 1'b0};
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
          end
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_idx_q != LAST_IDX) begin
            // Next frame starts on the very next cycle: no idle gap between bytes
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = pick_byte(payload_q, byte_idx_q + 1'b1);
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The line value is derived from where we are going, so bit_out is a clean flop output
    case (state_d)
      S_START: bit_out_d = 1'b0;
      S_DATA:  bit_out_d = (MSB_FIRST != 0) ? shift_d[7] : shift_d[0];
      default: bit_out_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset abandons any partial frame and idles the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= '0;
      payload_q  <= '0;
      shift_q    <= 8'h00;
      bit_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      payload_q  <= payload_d;
      shift_q    <= shift_d;
      bit_out_q  <= bit_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.bit_out = bit_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_uart_tx_result.sv
// tb/tb_uart_tx_result.sv - directed self-checking bench for uart_tx_result
module tb_uart_tx_result;

  localparam int CC = 434;
  localparam int CD = 8;
  localparam int ND = 10;
  localparam int LAST_D = 10 * ND * CD;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_result_if #(.NUM_BYTES(1))  ifa ();
  uart_tx_result_if #(.NUM_BYTES(1))  ifb ();
  uart_tx_result_if #(.NUM_BYTES(10)) ifc ();
  uart_tx_result_if #(.NUM_BYTES(10)) ifd ();

  uart_tx_result #(.CLKS_PER_BIT(4),  .NUM_BYTES(1),  .MSB_FIRST(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_tx_result #(.CLKS_PER_BIT(4),  .NUM_BYTES(1),  .MSB_FIRST(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_tx_result #(.CLKS_PER_BIT(CC), .NUM_BYTES(10), .MSB_FIRST(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
  uart_tx_result #(.CLKS_PER_BIT(CD), .NUM_BYTES(ND), .MSB_FIRST(0)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

  // Expected line level for dut_d at cycle offset s (s=1 is the first start-bit cycle)
  function automatic logic exp_d(input logic [79:0] p, input int s);
    int o, j, slot;
    logic [79:0] t;
    if (s < 1 || s > LAST_D) return 1'b1;
    o    = s - 1;
    j    = o / (10 * CD);
    slot = (o % (10 * CD)) / CD;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    t = p >> (8 * (9 - j));
    return t[slot-1];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1; ifd.start = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n == 3) begin
        rst = 1'b0;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({ifa.bit_out, ifa.busy, ifa.done} !== 3'b100)
        $display("FAIL reset_a n=%0d got {bit_out,busy,done}=%b want 100", n, {ifa.bit_out, ifa.busy, ifa.done});
      else passed++;
      total++;
      if ({ifb.bit_out, ifb.busy, ifb.done} !== 3'b100)
        $display("FAIL reset_b n=%0d got {bit_out,busy,done}=%b want 100", n, {ifb.bit_out, ifb.busy, ifb.done});
      else passed++;
      total++;
      if ({ifc.bit_out, ifc.busy, ifc.done} !== 3'b100)
        $display("FAIL reset_c n=%0d got {bit_out,busy,done}=%b want 100", n, {ifc.bit_out, ifc.busy, ifc.done});
      else passed++;
      total++;
      if ({ifd.bit_out, ifd.busy, ifd.done} !== 3'b100)
        $display("FAIL reset_d n=%0d got {bit_out,busy,done}=%b want 100", n, {ifd.bit_out, ifd.busy, ifd.done});
      else passed++;
    end
  endtask

  task automatic test_single_lsb();
    bit slots [0:9];
    logic eb;
    slots = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    ifa.d_in = 8'hA5; ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0; ifa.d_in = 8'h00;
    for (int s = 1; s <= 43; s++) begin
      @(negedge clk);
      eb = (s <= 40) ? slots[(s-1)/4] : 1'b1;
      total++;
      if (ifa.bit_out !== eb) $display("FAIL lsb_bit s=%0d got %b want %b", s, ifa.bit_out, eb);
      else passed++;
      total++;
      if (ifa.busy !== (s <= 40)) $display("FAIL lsb_busy s=%0d got %b want %b", s, ifa.busy, (s <= 40));
      else passed++;
      total++;
      if (ifa.done !== (s == 41)) $display("FAIL lsb_done s=%0d got %b want %b", s, ifa.done, (s == 41));
      else passed++;
    end
  endtask

  task automatic test_single_msb();
    bit slots [0:9];
    logic eb;
    slots = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    ifb.d_in = 8'h81; ifb.start = 1'b1;
    @(posedge clk); #1 ifb.start = 1'b0; ifb.d_in = 8'h00;
    for (int s = 1; s <= 43; s++) begin
      @(negedge clk);
      eb = (s <= 40) ? slots[(s-1)/4] : 1'b1;
      total++;
      if (ifb.bit_out !== eb) $display("FAIL msb_bit s=%0d got %b want %b", s, ifb.bit_out, eb);
      else passed++;
      total++;
      if (ifb.busy !== (s <= 40)) $display("FAIL msb_busy s=%0d got %b want %b", s, ifb.busy, (s <= 40));
      else passed++;
      total++;
      if (ifb.done !== (s == 41)) $display("FAIL msb_done s=%0d got %b want %b", s, ifb.done, (s == 41));
      else passed++;
    end
  endtask

  // Loopback through a mid-bit sampling receiver at the real baud divisor
  task automatic test_multi_byte();
    int t0, rel, w;
    logic [7:0] rx;
    bit timed_out;
    timed_out = 1'b0;
    @(negedge clk);
    ifc.d_in = 80'h00010203040506070809; ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    t0 = cyc;
    for (int j = 0; j < 10 && !timed_out; j++) begin
      w = 0;
      @(negedge clk);
      while (ifc.bit_out !== 1'b0 && w < 20 * CC) begin
        @(negedge clk);
        w++;
      end
      rel = cyc - t0 + 1;
      total++;
      if (ifc.bit_out !== 1'b0) begin
        $display("FAIL rx_start_timeout byte=%0d got no start bit within %0d cycles", j, 20 * CC);
        timed_out = 1'b1;
      end else passed++;
      if (!timed_out) begin
        total++;
        if (rel !== 1 + j * 10 * CC) $display("FAIL rx_gap byte=%0d start cycle got %0d want %0d", j, rel, 1 + j * 10 * CC);
        else passed++;
        repeat (CC / 2) @(negedge clk);
        total++;
        if (ifc.bit_out !== 1'b0) $display("FAIL rx_start_mid byte=%0d got %b want 0", j, ifc.bit_out);
        else passed++;
        for (int i = 0; i < 8; i++) begin
          repeat (CC) @(negedge clk);
          rx[i] = ifc.bit_out;
        end
        total++;
        if (rx !== 8'(j)) $display("FAIL rx_byte byte=%0d got %h want %h", j, rx, 8'(j));
        else passed++;
        repeat (CC) @(negedge clk);
        total++;
        if (ifc.bit_out !== 1'b1) $display("FAIL rx_stop byte=%0d got %b want 1", j, ifc.bit_out);
        else passed++;
      end
    end
    w = 0;
    while (ifc.done !== 1'b1 && w < 4 * CC) begin
      @(negedge clk);
      w++;
    end
    rel = cyc - t0 + 1;
    total++;
    if (rel !== 10 * 10 * CC + 1 || ifc.done !== 1'b1)
      $display("FAIL multi_done got done=%b at cycle %0d want 1 at %0d", ifc.done, rel, 10 * 10 * CC + 1);
    else passed++;
    total++;
    if (ifc.busy !== 1'b0) $display("FAIL multi_busy_at_done got %b want 0", ifc.busy);
    else passed++;
    @(negedge clk);
    total++;
    if (ifc.done !== 1'b0) $display("FAIL multi_done_width got %b want 0", ifc.done);
    else passed++;
  endtask

  // Cycle-exact check of one dut_d transfer whose start was sampled at the last posedge.
  // inject_at>0 pulses start with different data mid-transfer; restart re-requests in the done cycle.
  task automatic run_transfer_d(input logic [79:0] p, input int inject_at,
                                input bit restart, input logic [79:0] p_next);
    int last_s;
    last_s = restart ? LAST_D + 1 : LAST_D + 3;
    for (int s = 1; s <= last_s; s++) begin
      @(negedge clk);
      total++;
      if (ifd.bit_out !== exp_d(p, s)) $display("FAIL d_bit s=%0d got %b want %b", s, ifd.bit_out, exp_d(p, s));
      else passed++;
      total++;
      if (ifd.busy !== (s <= LAST_D)) $display("FAIL d_busy s=%0d got %b want %b", s, ifd.busy, (s <= LAST_D));
      else passed++;
      total++;
      if (ifd.done !== (s == LAST_D + 1)) $display("FAIL d_done s=%0d got %b want %b", s, ifd.done, (s == LAST_D + 1));
      else passed++;
      if (inject_at > 0 && s == inject_at) begin
        ifd.start = 1'b1; ifd.d_in = p_next;
      end
      if (inject_at > 0 && s == inject_at + 1) ifd.start = 1'b0;
      if (restart && s == last_s) begin
        ifd.start = 1'b1; ifd.d_in = p_next;
      end
    end
    if (restart) begin
      @(posedge clk); #1 ifd.start = 1'b0; ifd.d_in = '0;
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] p1, p2;
    p1 = 80'h11223344556677889900;
    p2 = 80'hA5C30FF05A3C966901FE;
    @(negedge clk);
    ifd.d_in = p1; ifd.start = 1'b1;
    @(posedge clk); #1 ifd.start = 1'b0;
    run_transfer_d(p1, 37, 1'b1, p2);
    run_transfer_d(p2, 0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    logic [79:0] p3;
    p3 = 80'h0102040810204080FF7E;
    @(negedge clk);
    ifd.d_in = p3; ifd.start = 1'b1;
    @(posedge clk); #1 ifd.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({ifd.bit_out, ifd.busy, ifd.done} !== 3'b100)
        $display("FAIL reset_mid n=%0d got {bit_out,busy,done}=%b want 100", n, {ifd.bit_out, ifd.busy, ifd.done});
      else passed++;
    end
    ifd.d_in = p3; ifd.start = 1'b1;
    @(posedge clk); #1 ifd.start = 1'b0;
    run_transfer_d(p3, 0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.d_in = '0;
    ifb.start = 1'b0; ifb.d_in = '0;
    ifc.start = 1'b0; ifc.d_in = '0;
    ifd.start = 1'b0; ifd.d_in = '0;
    test_reset();
    test_single_lsb();
    test_single_msb();
    test_multi_byte();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
